breakout_game_ctrl: RTL

//   Game-flow sequencer for the Breakout VGA datapath. Runs a frame-paced FSM
//   (IDLE/SERVE/PLAY/MISS/OVER/WIN), counts lives and bricks taken, and gates
//   the 60 Hz animation engine with run_en/ball_reset. Sits between the refresh

---
 rtl/breakout_game_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/breakout_game_ctrl.sv
// Breakout game-flow sequencer.
// Frame-paced FSM that serves the ball, lets the animation engine run, and
// tracks lives and bricks taken until the game is won or lost.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a button press on a frame tick to start a game
// SERVE | ball recentred, animation frozen for SERVE_FRAMES ticks
// PLAY  | animation running, brick_hit / ball_lost events counted
// MISS  | ball lost with lives left, frozen for MISS_FRAMES ticks
// OVER  | no lives left, gameover shown for END_FRAMES ticks
// WIN   | all bricks taken, status shown for END_FRAMES ticks
module breakout_game_ctrl #(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned NBRICKS      = 8,
    parameter int unsigned SERVE_FRAMES = 120,
    parameter int unsigned MISS_FRAMES  = 60,
    parameter int unsigned END_FRAMES   = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick60hz,
    input  logic [1:0] btn,
    input  logic       brick_hit,
    input  logic       ball_lost,
    output logic       run_en,
    output logic       ball_reset,
    output logic [2:0] state,
    output logic [1:0] lives,
    output logic [3:0] bricks_taken,
    output logic       gameover,
    output logic       status
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } state_t;

    localparam logic [1:0] LIVES_LD = 2'(LIVES);
    localparam logic [3:0] NB_LD    = 4'(NBRICKS);
    localparam logic [7:0] SERVE_LD = 8'(SERVE_FRAMES);
    localparam logic [7:0] MISS_LD  = 8'(MISS_FRAMES);
    localparam logic [7:0] END_LD   = 8'(END_FRAMES);

    state_t     st;
    logic [7:0] frame_cnt;
    logic       expiry;
    logic [3:0] brick_next;

    assign state = st;

    // Timed phase ends on the frame tick that sees the last remaining frame.
    assign expiry = tick60hz && (frame_cnt == 8'd1);

    // Brick count after one more hit, held at the target once reached.
    assign brick_next = (bricks_taken >= NB_LD) ? NB_LD : bricks_taken + 4'd1;

    // Game-flow FSM with registered outputs and frame down-counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st           <= ST_IDLE;
            frame_cnt    <= 8'd0;
            lives        <= 2'd0;
            bricks_taken <= 4'd0;
            run_en       <= 1'b0;
            ball_reset   <= 1'b0;
            gameover     <= 1'b0;
            status       <= 1'b0;
        end else begin
            ball_reset <= 1'b0;
            if (tick60hz && frame_cnt != 8'd0) begin
                frame_cnt <= frame_cnt - 8'd1;
            end
            case (st)
                ST_IDLE: begin
                    run_en   <= 1'b0;
                    gameover <= 1'b0;
                    status   <= 1'b0;
                    if (tick60hz && btn != 2'b00) begin
                        st           <= ST_SERVE;
                        lives        <= LIVES_LD;
                        bricks_taken <= 4'd0;
                        frame_cnt    <= SERVE_LD;
                        ball_reset   <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (expiry) begin
                        st     <= ST_PLAY;
                        run_en <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (brick_hit) begin
                        bricks_taken <= brick_next;
                    end
                    // A winning brick takes precedence over a simultaneous miss.
                    if (brick_hit && brick_next == NB_LD) begin
                        st        <= ST_WIN;
                        status    <= 1'b1;
                        run_en    <= 1'b0;
                        frame_cnt <= END_LD;
                    end else if (ball_lost) begin
                        run_en <= 1'b0;
                        if (lives <= 2'd1) begin
                            lives     <= 2'd0;
                            st        <= ST_OVER;
                            gameover  <= 1'b1;
                            frame_cnt <= END_LD;
                        end else begin
                            lives     <= lives - 2'd1;
                            st        <= ST_MISS;
                            frame_cnt <= MISS_LD;
                        end
                    end
                end
                ST_MISS: begin
                    if (expiry) begin
                        st         <= ST_SERVE;
                        frame_cnt  <= SERVE_LD;
                        ball_reset <= 1'b1;
                    end
                end
                ST_OVER, ST_WIN: begin
                    if (expiry) begin
                        st       <= ST_IDLE;
                        gameover <= 1'b0;
                        status   <= 1'b0;
                    end
                end
                default: begin
                    st        <= ST_IDLE;
                    frame_cnt <= 8'd0;
                    run_en    <= 1'b0;
                    gameover  <= 1'b0;
                    status    <= 1'b0;
                end
            endcase
        end
    end

endmodule
